level_tracker: RTL and testbench

- Game-progress controller that sits directly upstream of the seven-segment display stage.
- Debounces the player and start buttons and judges each press against a timing window from the game logic.
- Drives the 3-bit level value (0..5) that the display stage renders as level x100.
- Level 5 is the win level; the display stage blinks it, and this block holds it until restart.

---
 rtl/level_pkg.sv | 20 ++
 rtl/debounce_sync.sv | 66 ++++++
 rtl/level_tracker.sv | 150 +++++++++++++++
 tb/tb_level_tracker.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/level_pkg.sv
// Shared types and constants for the level tracker: FSM state encoding, level width,
// default win level and the saturating level increment.
package level_pkg;

  localparam int unsigned LVL_W       = 3;
  localparam int unsigned MAX_LVL_DEF = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPlay = 2'd1,
    StCool = 2'd2,
    StWin  = 2'd3
  } state_e;

  function automatic logic [LVL_W-1:0] lvl_inc_sat(input logic [LVL_W-1:0] lvl,
                                                   input logic [LVL_W-1:0] max_lvl);
    return (lvl < max_lvl) ? lvl + 1'b1 : max_lvl;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser, stability-counter debouncer and rising-edge pulse for one button.
// A button already held when reset releases must be seen released before it may pulse.
module debounce_sync
  import level_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CntW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic [1:0]      sync_q;
  logic [1:0]      vld_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            deb_q, deb_d;
  logic            deb_prev_q;
  logic            arm_q, arm_d;
  logic            pulse_q, pulse_d;

  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync_q[1] == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      deb_d = sync_q[1];
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // vld_q marks when the synchroniser holds real samples rather than reset zeros
  always_comb begin
    arm_d   = arm_q | (vld_q[1] & ~sync_q[1] & ~deb_q);
    pulse_d = arm_q & deb_q & ~deb_prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      vld_q      <= '0;
      cnt_q      <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      arm_q      <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], raw};
      vld_q      <= {vld_q[0], 1'b1};
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      arm_q      <= arm_d;
      pulse_q    <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/level_tracker.sv
// Game-progress controller: debounced buttons, timing-window judging, level 0..MAX_LVL with
// cooldown and win hold. Define LVL_DECAY_EN to make a miss step the level down by one.
module level_tracker
  import level_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 250000,
  parameter int unsigned COOL_CYCLES = 12500000,
  parameter int unsigned MAX_LVL     = MAX_LVL_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic             start_raw,
  input  logic             window,
  output logic [LVL_W-1:0] Lvl,
  output logic             win,
  output logic             press_pulse
);

  localparam int unsigned CoolW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;
  localparam logic [CoolW-1:0] CoolLoad = CoolW'(COOL_CYCLES - 1);
  localparam logic [LVL_W-1:0] MaxLvl   = LVL_W'(MAX_LVL);

  if (MAX_LVL == 0 || MAX_LVL >= (1 << LVL_W)) begin : g_bad_max_lvl
    $error("MAX_LVL must be in 1..%0d", (1 << LVL_W) - 1);
  end

  // Async assert, synchronous release
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  logic btn_p;
  logic start_p;

  debounce_sync #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_deb (
    .clk  (clk),
    .rst_n(rst_int_n),
    .raw  (btn_raw),
    .pulse(btn_p)
  );

  debounce_sync #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_start_deb (
    .clk  (clk),
    .rst_n(rst_int_n),
    .raw  (start_raw),
    .pulse(start_p)
  );

  function automatic logic [LVL_W-1:0] judge(input logic [LVL_W-1:0] lvl, input logic hit);
    if (hit) begin
      return lvl_inc_sat(lvl, MaxLvl);
    end
`ifdef LVL_DECAY_EN
    return (lvl == '0) ? '0 : lvl - 1'b1;
`else
    return '0;
`endif
  endfunction

  state_e           state_q;
  logic [LVL_W-1:0] lvl_q;
  logic [LVL_W-1:0] lvl_nxt;
  logic             win_q;
  logic             press_q;
  logic [CoolW-1:0] cool_q;

  assign lvl_nxt = judge(lvl_q, window);

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
      lvl_q   <= '0;
      win_q   <= 1'b0;
      press_q <= 1'b0;
      cool_q  <= '0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        StIdle: begin
          lvl_q <= '0;
          if (start_p) begin
            state_q <= StPlay;
          end
        end
        StPlay: begin
          // start_p outranks a coincident press, which is dropped
          if (start_p) begin
            lvl_q  <= '0;
            cool_q <= '0;
          end else if (btn_p) begin
            lvl_q   <= lvl_nxt;
            press_q <= 1'b1;
            if (lvl_nxt == MaxLvl) begin
              state_q <= StWin;
              win_q   <= 1'b1;
            end else begin
              state_q <= StCool;
              cool_q  <= CoolLoad;
            end
          end
        end
        StCool: begin
          if (start_p) begin
            lvl_q   <= '0;
            cool_q  <= '0;
            state_q <= StPlay;
          end else if (cool_q == '0) begin
            state_q <= StPlay;
          end else begin
            cool_q <= cool_q - 1'b1;
          end
        end
        StWin: begin
          if (start_p) begin
            lvl_q   <= '0;
            win_q   <= 1'b0;
            state_q <= StPlay;
          end else begin
            lvl_q <= MaxLvl;
            win_q <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          lvl_q   <= '0;
          win_q   <= 1'b0;
        end
      endcase
    end
  end

  assign Lvl         = lvl_q;
  assign win         = win_q;
  assign press_pulse = press_q;

endmodule

// File: tb/tb_level_tracker.sv
// Directed bench for level_tracker with DEB_CYCLES=4, COOL_CYCLES=8; expected values are
// hand-computed. Define LVL_DECAY_EN for both bench and RTL to check the decay build.
module tb_level_tracker;
  import level_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       btn_raw;
  logic       start_raw;
  logic       window;
  logic [2:0] lvl;
  logic       win;
  logic       press_pulse;

  int n_total;
  int n_bad;
  int pulse_cnt;
  int btnp_cnt;
  int snap_p;
  int snap_b;
  int exp_miss;

  level_tracker #(
    .DEB_CYCLES (4),
    .COOL_CYCLES(8),
    .MAX_LVL    (5)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_raw    (btn_raw),
    .start_raw  (start_raw),
    .window     (window),
    .Lvl        (lvl),
    .win        (win),
    .press_pulse(press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (press_pulse) pulse_cnt++;
    if (u_dut.btn_p) btnp_cnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic b, input logic s, input logic w);
    btn_raw   = b;
    start_raw = s;
    window    = w;
    cycles(10);
    btn_raw   = 1'b0;
    start_raw = 1'b0;
    cycles(10);
    window    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_total   = 0;
    n_bad     = 0;
    pulse_cnt = 0;
    btnp_cnt  = 0;
    rst_n     = 1'b0;
    btn_raw   = 1'b0;
    start_raw = 1'b0;
    window    = 1'b0;
`ifdef LVL_DECAY_EN
    exp_miss = 2;
`else
    exp_miss = 0;
`endif

    cycles(3);
    check_val("rst_lvl", 32'(lvl), 0);
    check_val("rst_win", 32'(win), 0);
    check_val("rst_press", 32'(press_pulse), 0);
    check_val("rst_state", 32'(u_dut.state_q), 32'(StIdle));
    rst_n = 1'b1;
    cycles(6);

    // btn ignored in IDLE
    snap_p = pulse_cnt;
    press(1'b1, 1'b0, 1'b1);
    check_val("idle_lvl", 32'(lvl), 0);
    check_val("idle_press", 32'(pulse_cnt - snap_p), 0);
    check_val("idle_state", 32'(u_dut.state_q), 32'(StIdle));

    // start pulse latency DEB_CYCLES+3 = 7
    start_raw = 1'b1;
    repeat (6) @(posedge clk);
    #1 check_val("start_p_c6", 32'(u_dut.start_p), 0);
    @(posedge clk);
    #1 check_val("start_p_c7", 32'(u_dut.start_p), 1);
    @(posedge clk);
    #1 check_val("start_state", 32'(u_dut.state_q), 32'(StPlay));
    check_val("start_lvl", 32'(lvl), 0);
    cycles(2);
    start_raw = 1'b0;
    cycles(10);

    // five hits to WIN
    snap_p = pulse_cnt;
    for (int i = 1; i <= 5; i++) begin
      press(1'b1, 1'b0, 1'b1);
      check_val($sformatf("hit_lvl%0d", i), 32'(lvl), 32'(i));
    end
    check_val("win_flag", 32'(win), 1);
    check_val("win_pulses", 32'(pulse_cnt - snap_p), 5);
    check_val("win_state", 32'(u_dut.state_q), 32'(StWin));
    press(1'b1, 1'b0, 1'b1);
    check_val("win_hold_lvl", 32'(lvl), 5);
    check_val("win_hold_pulses", 32'(pulse_cnt - snap_p), 5);
    press(1'b0, 1'b1, 1'b0);
    check_val("restart_lvl", 32'(lvl), 0);
    check_val("restart_win", 32'(win), 0);
    check_val("restart_state", 32'(u_dut.state_q), 32'(StPlay));

    // miss at level 3
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0, 1'b1);
    check_val("pre_miss_lvl", 32'(lvl), 3);
    snap_p = pulse_cnt;
    press(1'b1, 1'b0, 1'b0);
    check_val("miss_lvl", 32'(lvl), 32'(exp_miss));
    check_val("miss_pulse", 32'(pulse_cnt - snap_p), 1);

    // second press lands during cooldown
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    press(1'b1, 1'b0, 1'b1);
    check_val("pre_cool_lvl", 32'(lvl), 2);
    snap_p  = pulse_cnt;
    snap_b  = btnp_cnt;
    window  = 1'b1;
    btn_raw = 1'b1;
    cycles(4);
    btn_raw = 1'b0;
    cycles(4);
    btn_raw = 1'b1;
    cycles(8);
    btn_raw = 1'b0;
    cycles(12);
    window  = 1'b0;
    check_val("cool_lvl", 32'(lvl), 3);
    check_val("cool_pulses", 32'(pulse_cnt - snap_p), 1);
    check_val("cool_btnp", 32'(btnp_cnt - snap_b), 2);

    // bounce then stable high
    snap_p = pulse_cnt;
    snap_b = btnp_cnt;
    window = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i % 2 == 0);
      cycles(2);
    end
    btn_raw = 1'b1;
    cycles(10);
    btn_raw = 1'b0;
    cycles(10);
    window = 1'b0;
    check_val("bounce_btnp", 32'(btnp_cnt - snap_b), 1);
    check_val("bounce_lvl", 32'(lvl), 4);
    check_val("bounce_pulse", 32'(pulse_cnt - snap_p), 1);

    // start and btn in the same cycle
    snap_p = pulse_cnt;
    press(1'b1, 1'b1, 1'b1);
    check_val("both_lvl", 32'(lvl), 0);
    check_val("both_pulse", 32'(pulse_cnt - snap_p), 0);
    check_val("both_state", 32'(u_dut.state_q), 32'(StPlay));

    // reset mid-cooldown with btn held through release
    window  = 1'b1;
    btn_raw = 1'b1;
    cycles(10);
    check_val("pre_rst_state", 32'(u_dut.state_q), 32'(StCool));
    check_val("pre_rst_lvl", 32'(lvl), 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_lvl", 32'(lvl), 0);
    check_val("async_rst_win", 32'(win), 0);
    check_val("async_rst_state", 32'(u_dut.state_q), 32'(StIdle));
    cycles(3);
    rst_n  = 1'b1;
    snap_b = btnp_cnt;
    cycles(20);
    check_val("held_btnp", 32'(btnp_cnt - snap_b), 0);
    btn_raw = 1'b0;
    window  = 1'b0;
    cycles(10);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b1);
    check_val("rearm_btnp", 32'(btnp_cnt - snap_b), 1);
    check_val("rearm_lvl", 32'(lvl), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
